// File: rtl/md_unit_pkg.sv
// Shared MD opcode constants, default latencies, state type and opcode decode helpers.
// Optional MDU_MADD_EN enables the madd/maddu/msub/msubu opcodes (9-12).
package md_unit_pkg;

    localparam logic [3:0] MDop_NONE  = 4'd0;
    localparam logic [3:0] MDop_MULT  = 4'd1;
    localparam logic [3:0] MDop_MULTU = 4'd2;
    localparam logic [3:0] MDop_DIV   = 4'd3;
    localparam logic [3:0] MDop_DIVU  = 4'd4;
    localparam logic [3:0] MDop_MFHI  = 4'd5;
    localparam logic [3:0] MDop_MFLO  = 4'd6;
    localparam logic [3:0] MDop_MTHI  = 4'd7;
    localparam logic [3:0] MDop_MTLO  = 4'd8;
    localparam logic [3:0] MDop_MADD  = 4'd9;
    localparam logic [3:0] MDop_MADDU = 4'd10;
    localparam logic [3:0] MDop_MSUB  = 4'd11;
    localparam logic [3:0] MDop_MSUBU = 4'd12;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MDop_DIV) || (op == MDop_DIVU);
    endfunction

    function automatic logic md_is_start(input logic [3:0] op);
        logic v_start;
        v_start = (op == MDop_MULT) || (op == MDop_MULTU) || md_is_div(op);
`ifdef MDU_MADD_EN
        v_start = v_start || (op == MDop_MADD) || (op == MDop_MADDU) ||
                  (op == MDop_MSUB) || (op == MDop_MSUBU);
`endif
        return v_start;
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// E-stage MD bus: opcode/operands from the pipeline register, start/busy/result/HI/LO back.
interface md_unit_if;
    import md_unit_pkg::*;

    logic [3:0]  E_MDop;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_MD_start;
    logic        E_MD_busy;
    logic [31:0] E_MD_out;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output E_MDop, E_A, E_B,
        input  E_MD_start, E_MD_busy, E_MD_out, HI, LO
    );

    modport slave (
        input  E_MDop, E_A, E_B,
        output E_MD_start, E_MD_busy, E_MD_out, HI, LO
    );
endinterface

// File: rtl/md_unit_calc.sv
// md_calc: combinational MD arithmetic producing the 64-bit {sHI,sLO} shadow value.
// Accumulate ops (madd family) are compiled in only under MDU_MADD_EN.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [63:0] o_res
);
    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_q_s;
    logic signed [31:0] w_r_s;
    logic [31:0]        w_q_u;
    logic [31:0]        w_r_u;
    logic               w_b_zero;
    logic               w_s_ovf;

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'h0, i_a} * {32'h0, i_b};

    assign w_sa     = $signed(i_a);
    assign w_sb     = $signed(i_b);
    assign w_q_s    = w_sa / w_sb;
    assign w_r_s    = w_sa % w_sb;
    assign w_q_u    = i_a / i_b;
    assign w_r_u    = i_a % i_b;
    assign w_b_zero = (i_b == 32'h0);
    assign w_s_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    always_comb begin
        o_res = {i_hi, i_lo};
        case (i_op)
            MDop_MULT:  o_res = w_prod_s;
            MDop_MULTU: o_res = w_prod_u;
            MDop_DIV: begin
                if (w_s_ovf)
                    o_res = {32'h0, 32'h8000_0000};
                else if (!w_b_zero)
                    o_res = {w_r_s, w_q_s};
            end
            MDop_DIVU: begin
                if (!w_b_zero)
                    o_res = {w_r_u, w_q_u};
            end
`ifdef MDU_MADD_EN
            MDop_MADD:  o_res = {i_hi, i_lo} + w_prod_s;
            MDop_MADDU: o_res = {i_hi, i_lo} + w_prod_u;
            MDop_MSUB:  o_res = {i_hi, i_lo} - w_prod_s;
            MDop_MSUBU: o_res = {i_hi, i_lo} - w_prod_u;
`endif
            default:    o_res = {i_hi, i_lo};
        endcase
    end
endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO, fixed-latency busy window and mfhi/mflo/mthi/mtlo.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu.
//
// state   | meaning
// ST_IDLE | accepts start, mthi, mtlo
// ST_BUSY | result held in shadow; counter runs down, commit to HI/LO when it reaches 1
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);
    localparam logic [3:0] LP_MULT_N = MULT_CYCLES[3:0];
    localparam logic [3:0] LP_DIV_N  = DIV_CYCLES[3:0];

    md_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [63:0] r_sres;

    md_state_t   w_state_nx;
    logic [3:0]  w_cnt_nx;
    logic [31:0] w_hi_nx;
    logic [31:0] w_lo_nx;
    logic [63:0] w_sres_nx;
    logic [63:0] w_calc;
    logic        w_start;
    logic [3:0]  w_lat;

    assign w_start = md_is_start(bus.E_MDop);
    assign w_lat   = md_is_div(bus.E_MDop) ? LP_DIV_N : LP_MULT_N;

    md_calc u_calc (
        .i_op  (bus.E_MDop),
        .i_a   (bus.E_A),
        .i_b   (bus.E_B),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_res (w_calc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'h0;
            r_lo    <= 32'h0;
            r_sres  <= 64'h0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_sres  <= w_sres_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_sres_nx  = r_sres;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_sres_nx  = w_calc;
                    w_cnt_nx   = w_lat;
                    w_state_nx = ST_BUSY;
                end else if (bus.E_MDop == MDop_MTHI) begin
                    w_hi_nx = bus.E_A;
                end else if (bus.E_MDop == MDop_MTLO) begin
                    w_lo_nx = bus.E_A;
                end
            end
            ST_BUSY: begin
                // Requests seen here are protocol violations and are dropped.
                if (r_cnt <= 4'd1) begin
                    w_hi_nx    = r_sres[63:32];
                    w_lo_nx    = r_sres[31:0];
                    w_cnt_nx   = 4'd0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign bus.E_MD_start = w_start;
    assign bus.E_MD_busy  = (r_state == ST_BUSY);
    assign bus.HI         = r_hi;
    assign bus.LO         = r_lo;
    assign bus.E_MD_out   = (bus.E_MDop == MDop_MFHI) ? r_hi :
                            (bus.E_MDop == MDop_MFLO) ? r_lo : 32'h0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && r_state == ST_BUSY &&
            (w_start || bus.E_MDop == MDop_MTHI || bus.E_MDop == MDop_MTLO))
            $display("md_unit warning: MD request op=%0d ignored while busy", bus.E_MDop);
    end
`endif
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed op sequence, expected {HI,LO} queued at issue, checked at commit.
// Define MDU_MADD_EN for both RTL and bench to exercise the madd path.
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    md_unit_if bus ();

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one start op; entered and left at posedge+1.
    task automatic do_md(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int n, input logic [31:0] ehi,
                         input logic [31:0] elo, input bit viol);
        logic [63:0] v_exp;
        sb_q.push_back({ehi, elo});
        bus.E_MDop = op; bus.E_A = a; bus.E_B = b;
        @(negedge clk);
        chk({tag, "_start"}, {31'h0, bus.E_MD_start}, 32'h1);
        chk({tag, "_busy_c0"}, {31'h0, bus.E_MD_busy}, 32'h0);
        @(posedge clk); #1;
        bus.E_MDop = MDop_NONE;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", tag, k), {31'h0, bus.E_MD_busy}, 32'h1);
            if (k == n) begin
                chk({tag, "_hi_old"}, bus.HI, m_hi);
                chk({tag, "_lo_old"}, bus.LO, m_lo);
            end
            @(posedge clk); #1;
            if (viol && k == 1) begin
                bus.E_MDop = MDop_MTHI; bus.E_A = 32'hDEAD_BEEF;
            end else begin
                bus.E_MDop = MDop_NONE;
            end
        end
        @(negedge clk);
        chk({tag, "_busy_done"}, {31'h0, bus.E_MD_busy}, 32'h0);
        if (sb_q.size() == 0) begin
            checks++; failures++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end else begin
            v_exp = sb_q.pop_front();
            chk({tag, "_hi"}, bus.HI, v_exp[63:32]);
            chk({tag, "_lo"}, bus.LO, v_exp[31:0]);
            m_hi = v_exp[63:32];
            m_lo = v_exp[31:0];
        end
        @(posedge clk); #1;
    endtask

    task automatic do_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
        bus.E_MDop = op; bus.E_A = a;
        @(negedge clk);
        chk({tag, "_nostart"}, {31'h0, bus.E_MD_start}, 32'h0);
        @(posedge clk); #1;
        bus.E_MDop = MDop_NONE;
        if (op == MDop_MTHI) m_hi = a; else m_lo = a;
        @(negedge clk);
        chk({tag, "_busy"}, {31'h0, bus.E_MD_busy}, 32'h0);
        chk({tag, "_hi"}, bus.HI, m_hi);
        chk({tag, "_lo"}, bus.LO, m_lo);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.E_MDop = MDop_NONE; bus.E_A = 32'h0; bus.E_B = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'h0, bus.E_MD_busy}, 32'h0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_md("mult",   MDop_MULT,  32'hFFFF_FFFF, 32'h2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        do_md("multu",  MDop_MULTU, 32'hFFFF_FFFF, 32'h2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        do_md("mult_mn",MDop_MULT,  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0, 1'b0);
        do_md("div",    MDop_DIV,   32'hFFFF_FFF9, 32'h2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_md("divu",   MDop_DIVU,  32'h7, 32'h2, 10, 32'h1, 32'h3, 1'b1);
        do_md("div_ovf",MDop_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);

        do_mt("mthi", MDop_MTHI, 32'h11);
        do_mt("mtlo", MDop_MTLO, 32'h22);
        do_md("div0", MDop_DIVU, 32'h5, 32'h0, 10, 32'h11, 32'h22, 1'b0);

        bus.E_MDop = MDop_MFHI; #1;
        chk("mfhi", bus.E_MD_out, m_hi);
        bus.E_MDop = MDop_MFLO; #1;
        chk("mflo", bus.E_MD_out, m_lo);
        bus.E_MDop = MDop_NONE; #1;
        chk("mfnone", bus.E_MD_out, 32'h0);
        bus.E_MDop = 4'd13; #1;
        chk("op13_start", {31'h0, bus.E_MD_start}, 32'h0);
        bus.E_MDop = MDop_NONE;
        @(posedge clk); #1;

`ifdef MDU_MADD_EN
        do_mt("madd_prehi", MDop_MTHI, 32'h0);
        do_mt("madd_prelo", MDop_MTLO, 32'hFFFF_FFFF);
        do_md("madd", MDop_MADD, 32'h1, 32'h1, 5, 32'h1, 32'h0, 1'b0);
`else
        bus.E_MDop = MDop_MADD; bus.E_A = 32'h1; bus.E_B = 32'h1;
        @(negedge clk);
        chk("op9_start", {31'h0, bus.E_MD_start}, 32'h0);
        @(posedge clk); #1;
        bus.E_MDop = MDop_NONE;
        @(negedge clk);
        chk("op9_busy", {31'h0, bus.E_MD_busy}, 32'h0);
        chk("op9_hi", bus.HI, m_hi);
        chk("op9_lo", bus.LO, m_lo);
        @(posedge clk); #1;
`endif

        // Reset in busy cycle 2 discards the pending 3*4 result.
        bus.E_MDop = MDop_MULT; bus.E_A = 32'h3; bus.E_B = 32'h4;
        @(posedge clk); #1;
        bus.E_MDop = MDop_NONE;
        @(posedge clk); #1;
        reset = 1'b1; #1;
        chk("rst_mid_busy", {31'h0, bus.E_MD_busy}, 32'h0);
        chk("rst_mid_hi", bus.HI, 32'h0);
        chk("rst_mid_lo", bus.LO, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rst_nocommit_busy", {31'h0, bus.E_MD_busy}, 32'h0);
        chk("rst_nocommit_hi", bus.HI, 32'h0);
        chk("rst_nocommit_lo", bus.LO, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
